sdram_if_arbiter: RTL and testbench

Single-clock N-port arbiter for the internal SDRAM controller interface (acc/we/adr/dat/sel/ack/idle). It lets several on-chip masters, such as DMA engines or a CPU-side bridge, share one sdram_ctrl instance in the sdram_clk domain, with no CDC buffering. Compared with the earlier fixed arbiter, it adds:
- parametrised port count and data width
- selectable fixed-priority or round-robin policy
- a per-grant beat limit that forces re-arbitration to bound latency.

---
 rtl/sdram_if_pkg.sv | 21 ++
 rtl/sdram_if_arbiter_arb_pick.sv | 35 +++
 rtl/sdram_if_arbiter.sv | 143 ++++++++++++++
 tb/tb_sdram_if_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_if_pkg.sv
// Shared types and helpers for the SDRAM interface arbiter and future bus arbiters.
package sdram_if_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/sdram_if_arbiter_arb_pick.sv
// One-hot winner selection over a request vector.
// mode=0: lowest index wins. mode=1: first requester at or above base, wrapping.
module arb_pick #(
  parameter int N  = 4,
  parameter int BW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [BW-1:0] base,
  input  logic          mode,
  output logic [N-1:0]  win
);

  // Two passes: first only ports at or above base (round robin), then any port,
  // which handles the wrap and the fixed-priority case in one structure.
  always_comb begin
    logic found;
    int   base_i;
    win    = '0;
    found  = 1'b0;
    base_i = int'(base);
    for (int j = 0; j < N; j++) begin
      if (!found && req[j] && mode && (j >= base_i)) begin
        win[j] = 1'b1;
        found  = 1'b1;
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!found && req[j]) begin
        win[j] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_if_arbiter.sv
// N-port arbiter in front of sdram_ctrl: picks one master, muxes its request onto
// the controller interface and forwards the controller acks back to it.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | no owner; pick a winner once the controller reports idle
// ST_GRANT   | owner's acc/we/adr/dat/sel reach the controller, acks forwarded
// ST_RELEASE | acc dropped, owner held until the controller goes idle again
module sdram_if_arbiter
  import sdram_if_pkg::*;
#(
  parameter int PORTS     = 4,
  parameter int DW        = 16,
  parameter int AW        = 32,
  parameter int SW        = DW / 8,
  parameter int ARB_MODE  = 1,
  parameter int MAX_BEATS = 8,
  parameter int CW        = 4
) (
  input  logic                  sdram_clk,
  input  logic                  sdram_rst_n,
  input  logic [PORTS-1:0]      p_acc_i,
  input  logic [PORTS-1:0]      p_we_i,
  input  logic [PORTS*AW-1:0]   p_adr_i,
  input  logic [PORTS*DW-1:0]   p_dat_i,
  input  logic [PORTS*SW-1:0]   p_sel_i,
  output logic [PORTS-1:0]      p_ack_o,
  output logic [DW-1:0]         p_dat_o,
  output logic [AW-1:0]         p_adr_o,
  output logic [PORTS-1:0]      grant_o,
  input  logic                  idle_i,
  output logic                  acc_o,
  output logic                  we_o,
  output logic [AW-1:0]         adr_o,
  output logic [DW-1:0]         dat_o,
  output logic [SW-1:0]         sel_o,
  input  logic                  ack_i,
  input  logic [DW-1:0]         dat_i,
  input  logic [AW-1:0]         adr_i
);

  localparam int BW = (PORTS > 1) ? clog2(PORTS) : 1;
  // Compare value for the beat limit; the ack that hits it is the last one of the grant.
  localparam logic [CW-1:0] LIMIT = (MAX_BEATS > 0) ? CW'(MAX_BEATS - 1) : '0;

  state_t           state, state_nxt;
  logic [PORTS-1:0] grant, grant_nxt, pick;
  logic [CW-1:0]    beat_cnt, beat_nxt;
  logic [BW-1:0]    rr_base, rr_nxt, gidx;
  logic             acc_g, others_wait, at_limit;

  arb_pick #(.N(PORTS), .BW(BW)) u_pick (
    .req  (p_acc_i),
    .base (rr_base),
    .mode (ARB_MODE == ARB_RR),
    .win  (pick)
  );

  assign acc_g       = |(p_acc_i & grant);
  assign others_wait = |(p_acc_i & ~grant);
  assign at_limit    = (MAX_BEATS > 0) && (beat_cnt == LIMIT);

  assign p_dat_o = dat_i;
  assign p_adr_o = adr_i;
  assign grant_o = grant;

  // Request mux: port 0 drives the controller fields whenever nobody holds the grant.
  always_comb begin
    gidx  = '0;
    we_o  = p_we_i[0];
    adr_o = p_adr_i[0 +: AW];
    dat_o = p_dat_i[0 +: DW];
    sel_o = p_sel_i[0 +: SW];
    for (int i = 1; i < PORTS; i++) begin
      if (grant[i]) begin
        gidx  = BW'(i);
        we_o  = p_we_i[i];
        adr_o = p_adr_i[i*AW +: AW];
        dat_o = p_dat_i[i*DW +: DW];
        sel_o = p_sel_i[i*SW +: SW];
      end
    end
  end

  // State, grant, beat count and round-robin base registers.
  always_ff @(posedge sdram_clk) begin
    if (!sdram_rst_n) begin
      state    <= ST_IDLE;
      grant    <= '0;
      beat_cnt <= '0;
      rr_base  <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      beat_cnt <= beat_nxt;
      rr_base  <= rr_nxt;
    end
  end

  // Next-state logic plus acc/ack gating; acc_o and acks only ever flow in ST_GRANT.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    beat_nxt  = beat_cnt;
    rr_nxt    = rr_base;
    acc_o     = 1'b0;
    p_ack_o   = '0;
    case (state)
      ST_IDLE: begin
        beat_nxt = '0;
        if (idle_i && (|p_acc_i)) begin
          grant_nxt = pick;
          state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        acc_o   = acc_g;
        p_ack_o = grant & {PORTS{ack_i}};
        if (ack_i && (beat_cnt != '1)) beat_nxt = beat_cnt + CW'(1);
        if (!acc_g) begin
          state_nxt = ST_RELEASE;
        end else if (ack_i && at_limit && others_wait) begin
          // Owner keeps acc high and competes again after the release.
          state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (idle_i) begin
          grant_nxt = '0;
          state_nxt = ST_IDLE;
          if (ARB_MODE == ARB_RR) begin
            rr_nxt = (gidx == BW'(PORTS - 1)) ? '0 : gidx + BW'(1);
          end
        end
      end
      default: begin
        grant_nxt = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sdram_if_arbiter.sv
// Runs a round-robin and a fixed-priority arbiter side by side on shared inputs and
// checks every cycle against a transaction-level model of the arbitration rules.
module tb_sdram_if_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   p_acc, p_we;
  logic [127:0] p_adr;
  logic [63:0]  p_dat;
  logic [7:0]   p_sel;
  logic         idle, ack;
  logic [15:0]  cdat;
  logic [31:0]  cadr;

  logic [3:0]  ack_w   [2];
  logic [15:0] pdat_w  [2];
  logic [31:0] padr_w  [2];
  logic [3:0]  grant_w [2];
  logic        acc_w   [2];
  logic        we_w    [2];
  logic [31:0] adr_w   [2];
  logic [15:0] dat_w   [2];
  logic [1:0]  sel_w   [2];

  int n_tests = 0;
  int n_fail  = 0;

  sdram_if_arbiter #(.PORTS(4), .DW(16), .AW(32), .SW(2), .ARB_MODE(1), .MAX_BEATS(8), .CW(4)) dut_rr (
    .sdram_clk(clk), .sdram_rst_n(rst_n), .p_acc_i(p_acc), .p_we_i(p_we), .p_adr_i(p_adr),
    .p_dat_i(p_dat), .p_sel_i(p_sel), .p_ack_o(ack_w[0]), .p_dat_o(pdat_w[0]), .p_adr_o(padr_w[0]),
    .grant_o(grant_w[0]), .idle_i(idle), .acc_o(acc_w[0]), .we_o(we_w[0]), .adr_o(adr_w[0]),
    .dat_o(dat_w[0]), .sel_o(sel_w[0]), .ack_i(ack), .dat_i(cdat), .adr_i(cadr));

  sdram_if_arbiter #(.PORTS(4), .DW(16), .AW(32), .SW(2), .ARB_MODE(0), .MAX_BEATS(8), .CW(4)) dut_fx (
    .sdram_clk(clk), .sdram_rst_n(rst_n), .p_acc_i(p_acc), .p_we_i(p_we), .p_adr_i(p_adr),
    .p_dat_i(p_dat), .p_sel_i(p_sel), .p_ack_o(ack_w[1]), .p_dat_o(pdat_w[1]), .p_adr_o(padr_w[1]),
    .grant_o(grant_w[1]), .idle_i(idle), .acc_o(acc_w[1]), .we_o(we_w[1]), .adr_o(adr_w[1]),
    .dat_o(dat_w[1]), .sel_o(sel_w[1]), .ack_i(ack), .dat_i(cdat), .adr_i(cadr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase 0 = nobody owns the bus, 1 = owner transferring,
  // 2 = owner finished and waiting for the controller to go idle.
  int  m_ph [2];
  int  m_own [2];
  int  m_beats [2];
  int  m_base [2];
  bit  m_rr [2] = '{1'b1, 1'b0};
  bit  m_valid = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_winner(int k, logic [3:0] a);
    for (int s = 0; s < 4; s++) begin
      int p;
      p = m_rr[k] ? (m_base[k] + s) % 4 : s;
      if (((a >> p) & 4'd1) != 0) return p;
    end
    return -1;
  endfunction

  task automatic m_check(int k);
    string nm;
    int    g, src;
    logic  e_acc;
    logic [3:0] e_ack, e_grant;
    logic [50:0] e_mux, o_mux;
    nm      = (k == 0) ? "rr" : "fx";
    g       = m_own[k];
    src     = (g < 0) ? 0 : g;
    e_grant = (g < 0) ? 4'd0 : 4'(1 << g);
    e_acc   = (m_ph[k] == 1) && (((p_acc >> g) & 4'd1) != 0);
    e_ack   = (m_ph[k] == 1 && ack) ? 4'(1 << g) : 4'd0;
    e_mux   = {1'(p_we >> src), 32'(p_adr >> (src*32)), 16'(p_dat >> (src*16)), 2'(p_sel >> (src*2))};
    o_mux   = {we_w[k], adr_w[k], dat_w[k], sel_w[k]};
    chk({nm, ".acc_o"},   128'(acc_w[k]),   128'(e_acc));
    chk({nm, ".p_ack_o"}, 128'(ack_w[k]),   128'(e_ack));
    chk({nm, ".grant_o"}, 128'(grant_w[k]), 128'(e_grant));
    chk({nm, ".mux"},     128'(o_mux),      128'(e_mux));
    chk({nm, ".p_dat_o"}, 128'(pdat_w[k]),  128'(cdat));
    chk({nm, ".p_adr_o"}, 128'(padr_w[k]),  128'(cadr));
  endtask

  task automatic m_step(int k);
    int prev;
    if (!rst_n) begin
      m_ph[k] = 0; m_own[k] = -1; m_beats[k] = 0; m_base[k] = 0;
    end else begin
      case (m_ph[k])
        0: begin
          m_beats[k] = 0;
          if (idle && p_acc != 4'd0) begin
            m_own[k] = m_winner(k, p_acc);
            m_ph[k]  = 1;
          end
        end
        1: begin
          prev = m_beats[k];
          if (ack && m_beats[k] < 15) m_beats[k]++;
          if (((p_acc >> m_own[k]) & 4'd1) == 0) m_ph[k] = 2;
          else if (ack && prev == 7 && (p_acc & ~4'(1 << m_own[k])) != 4'd0) m_ph[k] = 2;
        end
        default: begin
          if (idle) begin
            if (m_rr[k]) m_base[k] = (m_own[k] + 1) % 4;
            m_own[k] = -1;
            m_ph[k]  = 0;
          end
        end
      endcase
    end
  endtask

  // One clock: apply inputs at the falling edge, optionally let a DUT's acc_o drive
  // the controller ack (src 1 = rr, 2 = fx), check both DUTs, advance the model.
  task automatic cyc(input logic [3:0] a, input logic idl, input logic ak, input logic rst, input int src);
    @(negedge clk);
    p_acc = a; idle = idl; ack = ak; rst_n = rst;
    p_we  = 4'($urandom);
    p_adr = {$urandom, $urandom, $urandom, $urandom};
    p_dat = {$urandom, $urandom};
    p_sel = 8'($urandom);
    cdat  = 16'($urandom);
    cadr  = $urandom;
    #1;
    if (src == 1) ack = acc_w[0];
    else if (src == 2) ack = acc_w[1];
    #1;
    if (m_valid) begin
      m_check(0);
      m_check(1);
    end
    m_step(0);
    m_step(1);
    if (!rst_n) m_valid = 1'b1;
  endtask

  task automatic do_reset(input int n);
    repeat (n) cyc(4'd0, 1'b1, 1'b0, 1'b0, 0);
  endtask

  // Simple masters: port i wants rounds[i] bursts of beats[i] acks, dropping acc
  // for one cycle between bursts. Grants are recorded as they appear.
  int rem [4], rounds [4], beats [4];
  bit cool [4];
  int ack_cnt [4];
  int stray;
  logic [3:0] seq [$];

  task automatic run_masters(input int src, input int budget);
    int k;
    logic [3:0] a, g, last_g;
    bit busy;
    k = src - 1;
    seq.delete();
    stray  = 0;
    last_g = 4'd0;
    for (int i = 0; i < 4; i++) begin rem[i] = beats[i]; cool[i] = 0; ack_cnt[i] = 0; end
    for (int c = 0; c < budget; c++) begin
      a = 4'd0; busy = 0;
      for (int i = 0; i < 4; i++) begin
        if (rem[i] > 0 && !cool[i]) a = a | 4'(1 << i);
        if (rem[i] > 0) busy = 1;
      end
      if (!busy) break;
      cyc(a, 1'b1, 1'b0, 1'b1, src);
      g = grant_w[k];
      if (g != 4'd0 && last_g == 4'd0) seq.push_back(g);
      last_g = g;
      for (int i = 0; i < 4; i++) cool[i] = 0;
      for (int i = 0; i < 4; i++) begin
        if (((ack_w[k] >> i) & 4'd1) != 0) begin
          ack_cnt[i]++;
          if (((g >> i) & 4'd1) == 0) stray++;
          if (rem[i] > 0) begin
            rem[i]--;
            if (rem[i] == 0 && rounds[i] > 1) begin
              rounds[i]--; rem[i] = beats[i]; cool[i] = 1;
            end
          end
        end
      end
    end
    chk("masters.done_in_budget", 128'(busy && (rem[0] + rem[1] + rem[2] + rem[3] > 0)), 128'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ra;
    int cnt;
    bit moved;
    p_acc = '0; p_we = '0; p_adr = '0; p_dat = '0; p_sel = '0;
    idle = 1'b1; ack = 1'b0; rst_n = 1'b0; cdat = '0; cadr = '0;
    for (int k = 0; k < 2; k++) begin m_ph[k] = 0; m_own[k] = -1; m_beats[k] = 0; m_base[k] = 0; end

    // Reset with every port requesting and the controller idle.
    repeat (3) cyc(4'b1111, 1'b1, 1'b0, 1'b0, 0);
    chk("reset.acc_rr",   128'(acc_w[0]),   128'(0));
    chk("reset.grant_fx", 128'(grant_w[1]), 128'(0));
    cyc(4'b1111, 1'b1, 1'b0, 1'b1, 0);
    cyc(4'b1111, 1'b1, 1'b0, 1'b1, 0);
    chk("first.grant_rr", 128'(grant_w[0]), 128'(4'b0001));
    chk("first.acc_fx",   128'(acc_w[1]),   128'(1));

    // Round robin between ports 1 and 3, two beats per burst.
    do_reset(2);
    beats = '{0, 2, 0, 2}; rounds = '{0, 2, 0, 1};
    run_masters(1, 60);
    chk("rr.n_grants", 128'(seq.size()), 128'(3));
    if (seq.size() == 3) begin
      chk("rr.grant0", 128'(seq[0]), 128'(4'b0010));
      chk("rr.grant1", 128'(seq[1]), 128'(4'b1000));
      chk("rr.grant2", 128'(seq[2]), 128'(4'b0010));
    end

    // Fixed priority: port 0 keeps coming back and starves port 2.
    do_reset(2);
    beats = '{2, 0, 2, 0}; rounds = '{3, 0, 1, 0};
    run_masters(2, 80);
    chk("fx.n_grants", 128'(seq.size()), 128'(4));
    if (seq.size() == 4) begin
      chk("fx.grant0", 128'(seq[0]), 128'(4'b0001));
      chk("fx.grant1", 128'(seq[1]), 128'(4'b0001));
      chk("fx.grant2", 128'(seq[2]), 128'(4'b0001));
      chk("fx.grant3", 128'(seq[3]), 128'(4'b0100));
    end

    // Beat limit: port 0 bursts 32 beats while port 1 waits for 4.
    do_reset(2);
    beats = '{32, 4, 0, 0}; rounds = '{1, 1, 0, 0};
    run_masters(1, 120);
    chk("limit.acks_p0", 128'(ack_cnt[0]), 128'(32));
    chk("limit.acks_p1", 128'(ack_cnt[1]), 128'(4));
    chk("limit.stray",   128'(stray),      128'(0));
    chk("limit.n_grants", 128'(seq.size()), 128'(3));
    if (seq.size() == 3) begin
      chk("limit.grant0", 128'(seq[0]), 128'(4'b0001));
      chk("limit.grant1", 128'(seq[1]), 128'(4'b0010));
      chk("limit.grant2", 128'(seq[2]), 128'(4'b0001));
    end

    // Stray acks in RELEASE/IDLE, and a controller that stays busy.
    do_reset(2);
    cyc(4'b0100, 1'b1, 1'b0, 1'b1, 0);
    cyc(4'b0100, 1'b1, 1'b1, 1'b1, 0);
    chk("rel.ack_in_grant", 128'(ack_w[0]), 128'(4'b0100));
    cyc(4'b0010, 1'b1, 1'b0, 1'b1, 0);
    repeat (5) begin
      cyc(4'b0010, 1'b0, 1'b1, 1'b1, 0);
      chk("rel.ack_busy",   128'(ack_w[0]),   128'(0));
      chk("rel.grant_busy", 128'(grant_w[0]), 128'(4'b0100));
      chk("rel.acc_busy",   128'(acc_w[0]),   128'(0));
    end
    cyc(4'b0010, 1'b1, 1'b1, 1'b1, 0);
    chk("rel.ack_release", 128'(ack_w[1]), 128'(0));
    cyc(4'b0010, 1'b1, 1'b1, 1'b1, 0);
    chk("rel.ack_idle",   128'(ack_w[0]),   128'(0));
    chk("rel.grant_idle", 128'(grant_w[0]), 128'(0));
    cyc(4'b0010, 1'b1, 1'b0, 1'b1, 0);
    chk("rel.next_grant", 128'(grant_w[0]), 128'(4'b0010));

    // Reset in the middle of a grant, then the beat limit counts from zero again.
    do_reset(2);
    cyc(4'b0011, 1'b1, 1'b0, 1'b1, 0);
    repeat (3) cyc(4'b0011, 1'b1, 1'b1, 1'b1, 0);
    cyc(4'b0011, 1'b1, 1'b1, 1'b0, 0);
    cyc(4'b0011, 1'b1, 1'b0, 1'b1, 0);
    chk("midrst.acc",   128'(acc_w[0]),   128'(0));
    chk("midrst.ack",   128'(ack_w[0]),   128'(0));
    chk("midrst.grant", 128'(grant_w[0]), 128'(0));
    cnt = 0; moved = 0;
    for (int c = 0; c < 20 && !moved; c++) begin
      cyc(4'b0011, 1'b1, 1'b1, 1'b1, 0);
      if (ack_w[0][0]) cnt++;
      if (grant_w[0] == 4'b0010) moved = 1;
    end
    chk("midrst.moved",    128'(moved), 128'(1));
    chk("midrst.p0_beats", 128'(cnt),   128'(8));

    // Random traffic, both policies checked against the model every cycle.
    do_reset(2);
    ra = 4'($urandom);
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(5) == 0) ra = ra ^ 4'(1 << i);
      cyc(ra, 1'($urandom_range(3) != 0), 1'($urandom_range(1)), 1'($urandom_range(99) != 0), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
